// File: rtl/ddr_rd_sum.sv
// DDR bandwidth-test read engine: issues NUM_BURSTS INCR read bursts from a
// base address, sums every returned 32-bit lane and keeps status counters.
module ddr_rd_sum #(
    parameter int DATA_W     = 64,
    parameter int ADDR_W     = 32,
    parameter int BURST_LEN  = 16,
    parameter int NUM_BURSTS = 1024,
    parameter int MAX_OUT    = 4
) (
    input  logic              m_axi_aclk,
    input  logic              m_axi_areset,
    input  logic              start,
    input  logic [ADDR_W-1:0] ddr_baseaddr,
    output logic [31:0]       partial_sum,
    output logic              busy,
    output logic              done,
    output logic [159:0]      probe,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [7:0]        m_axi_arlen,
    output logic [2:0]        m_axi_arsize,
    output logic [1:0]        m_axi_arburst,
    output logic [3:0]        m_axi_arcache,
    output logic [2:0]        m_axi_arprot,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rlast,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready
);

    localparam int BYTES_PER_BURST = BURST_LEN * DATA_W / 8;
    localparam int LANES           = DATA_W / 32;
    localparam int IDX_W           = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BYTES_PER_BURST);
    localparam logic [ADDR_W-1:0] ALIGN_MASK  = ~ADDR_W'(BYTES_PER_BURST - 1);
    localparam logic [31:0]       TOTAL_BEATS = 32'(NUM_BURSTS * BURST_LEN);
    localparam logic [31:0]       NUM_BURSTS_W = 32'(NUM_BURSTS);
    localparam logic [7:0]        MAX_OUT_W   = 8'(MAX_OUT);
    localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              start_q;
    logic [ADDR_W-1:0] ar_addr_q;
    logic [31:0]       bursts_issued, beats, cycle_cnt, err_cnt, sum_q;
    logic [7:0]        outstanding;
    logic [IDX_W-1:0]  beat_idx;
    logic              rready_q;

    logic              start_edge, ar_hs, r_hs, r_last_hs, beat_err;
    logic [31:0]       lane_sum;

    assign start_edge = start & ~start_q & (state_q == IDLE);
    // Valid is a pure function of counters that only change on the handshake
    // (outstanding can only fall meanwhile), so it holds stable until arready.
    assign m_axi_arvalid = (state_q == RUN) && (bursts_issued < NUM_BURSTS_W) &&
                           (outstanding < MAX_OUT_W);
    assign ar_hs     = m_axi_arvalid & m_axi_arready;
    assign r_hs      = m_axi_rvalid & rready_q;
    assign r_last_hs = r_hs & m_axi_rlast;
    assign beat_err  = (m_axi_rresp != 2'b00) || (m_axi_rlast != (beat_idx == LAST_IDX));

    always_comb begin
        // NOTE: default first so every path assigns the variable and no latch is inferred.
        lane_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_sum = lane_sum + m_axi_rdata[i*32 +: 32];
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_edge) state_d = RUN;
            RUN:     if (beats == TOTAL_BEATS) state_d = DONE;
            DONE:    if (!start) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
        if (m_axi_areset) begin
            state_q  <= IDLE;
            start_q  <= 1'b1;  // a level already high at release is not an edge
            rready_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples pre-edge values regardless of statement order.
            state_q  <= state_d;
            start_q  <= start;
            rready_q <= (state_d == RUN);
        end
    end

    always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
        if (m_axi_areset) begin
            ar_addr_q     <= '0;
            bursts_issued <= '0;
            outstanding   <= '0;
            beats         <= '0;
            cycle_cnt     <= '0;
            err_cnt       <= '0;
            sum_q         <= '0;
            beat_idx      <= '0;
        end else if (start_edge) begin
            ar_addr_q     <= ddr_baseaddr & ALIGN_MASK;
            bursts_issued <= '0;
            outstanding   <= '0;
            beats         <= '0;
            cycle_cnt     <= '0;
            err_cnt       <= '0;
            sum_q         <= '0;
            beat_idx      <= '0;
        end else if (state_q == RUN) begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (ar_hs) begin
                ar_addr_q     <= ar_addr_q + BURST_BYTES;
                bursts_issued <= bursts_issued + 32'd1;
            end
            // A stray early rlast must not drive the count below zero.
            if (ar_hs && !r_last_hs)
                outstanding <= outstanding + 8'd1;
            else if (!ar_hs && r_last_hs && outstanding != 8'd0)
                outstanding <= outstanding - 8'd1;
            if (r_hs) begin
                sum_q    <= sum_q + lane_sum;
                beats    <= beats + 32'd1;
                beat_idx <= (beat_idx == LAST_IDX) ? '0 : beat_idx + IDX_W'(1);
                if (beat_err) err_cnt <= err_cnt + 32'd1;
            end
        end
    end

    assign partial_sum   = sum_q;
    assign busy          = (state_q == RUN);
    assign done          = (state_q == DONE);
    assign m_axi_rready  = rready_q;
    assign m_axi_araddr  = ar_addr_q;
    assign m_axi_arlen   = 8'(BURST_LEN - 1);
    assign m_axi_arsize  = 3'($clog2(DATA_W / 8));
    assign m_axi_arburst = 2'b01;
    assign m_axi_arcache = 4'b0011;
    assign m_axi_arprot  = 3'b000;
    assign probe = {16'd0, outstanding, 6'd0, state_q, err_cnt, bursts_issued, beats, cycle_cnt};

endmodule

// File: tb/tb_ddr_rd_sum.sv
// Directed bench for ddr_rd_sum: small AXI read slave returning word index
// (a-base)>>2, configurable stalls/throttle/error injection.
module tb_ddr_rd_sum;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [31:0]  ddr_baseaddr;
    logic [31:0]  partial_sum;
    logic         busy, done;
    logic [159:0] probe;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic [3:0]   arcache;
    logic [2:0]   arprot;
    logic         arvalid, arready;
    logic [63:0]  rdata;
    logic [1:0]   rresp;
    logic         rlast, rvalid, rready;

    always #5 clk = ~clk;

    ddr_rd_sum #(
        .DATA_W(64), .ADDR_W(32), .BURST_LEN(4), .NUM_BURSTS(4), .MAX_OUT(2)
    ) dut (
        .m_axi_aclk(clk), .m_axi_areset(rst), .start(start), .ddr_baseaddr(ddr_baseaddr),
        .partial_sum(partial_sum), .busy(busy), .done(done), .probe(probe),
        .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
        .m_axi_arburst(arburst), .m_axi_arcache(arcache), .m_axi_arprot(arprot),
        .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_rdata(rdata),
        .m_axi_rresp(rresp), .m_axi_rlast(rlast), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    localparam logic [31:0] MBASE = 32'h1000_0000;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slave model state, shared with the stimulus process (disjoint time slots).
    logic [31:0] ar_q [0:15];
    logic [31:0] ar_log [0:15];
    int          q_wr, q_rd, r_beat, g_beat, ar_n;
    int          ar_stall, err_beat, early_beat, stall_seen, stable_viol;
    bit          r_throttle, thr, pend_ar, pend_r, stall_prev;
    logic [31:0] pend_addr, prev_addr, a, w;
    logic [7:0]  max_out;

    task automatic prep_run();
        q_wr = 0; q_rd = 0; r_beat = 0; g_beat = 0; ar_n = 0;
        ar_stall = 0; err_beat = -1; early_beat = -1; stall_seen = 0; stable_viol = 0;
        r_throttle = 0; thr = 0; max_out = '0; stall_prev = 0;
    endtask

    initial begin : slave
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0;
        pend_ar = 0; pend_r = 0;
        prep_run();
        forever begin
            @(negedge clk);
            if (rst) begin
                arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
                pend_ar = 0; pend_r = 0; q_wr = 0; q_rd = 0; r_beat = 0; g_beat = 0;
                stall_prev = 0;
            end else begin
                if (pend_ar) begin
                    ar_q[q_wr % 16] = pend_addr; q_wr++;
                    ar_log[ar_n % 16] = pend_addr; ar_n++;
                end
                if (pend_r) begin
                    rvalid = 1'b0; g_beat++;
                    if (r_beat == 3) begin r_beat = 0; q_rd++; end
                    else r_beat++;
                end
                if (ar_stall > 0) begin arready = 1'b0; ar_stall--; end
                else arready = 1'b1;
                if (!rvalid && q_rd != q_wr) begin
                    thr = ~thr;
                    if (!r_throttle || thr) begin
                        a      = ar_q[q_rd % 16] + 32'(r_beat * 8);
                        w      = (a - MBASE) >> 2;
                        rdata  = {w + 32'd1, w};
                        rlast  = (r_beat == 3) || (g_beat == early_beat);
                        rresp  = (g_beat == err_beat) ? 2'b10 : 2'b00;
                        rvalid = 1'b1;
                    end
                end
                #1;
                pend_ar   = arvalid && arready;
                pend_addr = araddr;
                pend_r    = rvalid && rready;
                if (stall_prev && (!arvalid || araddr != prev_addr)) stable_viol++;
                stall_prev = arvalid && !arready;
                prev_addr  = araddr;
                if (arvalid && !arready) stall_seen++;
                if (probe[143:136] > max_out) max_out = probe[143:136];
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 2000) begin tick(); n++; end
        check({tag, "_done"}, 64'(done), 64'd1);
    endtask

    logic [31:0] cyc1, cyc2;

    initial begin : stim
        rst = 1'b1; start = 1'b0; ddr_baseaddr = MBASE;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sum",     64'(partial_sum), 64'd0);
        check("rst_probe",   64'(probe == '0), 64'd1);
        check("rst_arvalid", 64'(arvalid), 64'd0);
        check("rst_rready",  64'(rready), 64'd0);
        check("rst_busy",    64'({busy, done}), 64'd0);
        rst = 1'b0;
        tick(); tick();

        // Zero-wait run
        prep_run(); start = 1'b1;
        wait_done("zw");
        check("zw_ar_n",  64'(ar_n), 64'd4);
        check("zw_ar0",   64'(ar_log[0]), 64'h1000_0000);
        check("zw_ar1",   64'(ar_log[1]), 64'h1000_0020);
        check("zw_ar2",   64'(ar_log[2]), 64'h1000_0040);
        check("zw_ar3",   64'(ar_log[3]), 64'h1000_0060);
        check("zw_sum",   64'(partial_sum), 64'd496);
        check("zw_beats", 64'(probe[63:32]), 64'd16);
        check("zw_burst", 64'(probe[95:64]), 64'd4);
        check("zw_err",   64'(probe[127:96]), 64'd0);
        check("zw_state", 64'(probe[129:128]), 64'd2);
        check("zw_arlen", 64'({arlen, arsize, arburst, arcache, arprot}),
              64'({8'd3, 3'd3, 2'b01, 4'b0011, 3'd0}));
        cyc1 = probe[31:0];
        start = 1'b0; tick(); tick();
        check("zw_idle", 64'({probe[129:128], done}), 64'd0);

        // AR stall plus 50% R throttle
        prep_run(); ar_stall = 10; r_throttle = 1; start = 1'b1;
        wait_done("st");
        check("st_stable",  64'(stable_viol), 64'd0);
        check("st_stalled", 64'(stall_seen >= 9), 64'd1);
        check("st_maxout",  64'(max_out <= 8'd2), 64'd1);
        check("st_sum",     64'(partial_sum), 64'd496);
        check("st_ar3",     64'(ar_log[3]), 64'h1000_0060);
        cyc2 = probe[31:0];
        check("st_cycles",  64'(cyc2 > cyc1), 64'd1);
        start = 1'b0; tick(); tick();

        // SLVERR on beat 5, extra early rlast on beat 9
        prep_run(); err_beat = 5; early_beat = 9; start = 1'b1;
        wait_done("er");
        check("er_err",   64'(probe[127:96]), 64'd2);
        check("er_sum",   64'(partial_sum), 64'd496);
        check("er_beats", 64'(probe[63:32]), 64'd16);
        start = 1'b0; tick(); tick();

        // Start pulse inside RUN is ignored
        prep_run(); start = 1'b1;
        tick(); tick(); tick();
        start = 1'b0; tick(); start = 1'b1;
        wait_done("pu");
        check("pu_cycles", 64'(probe[31:0]), 64'(cyc1));
        check("pu_sum",    64'(partial_sum), 64'd496);
        tick(); tick();
        check("pu_hold",   64'(done), 64'd1);
        start = 1'b0; tick(); tick();
        check("pu_idle",   64'({probe[129:128], done}), 64'd0);
        prep_run(); start = 1'b1; tick();
        check("re_busy",   64'(busy), 64'd1);
        check("re_clear",  64'({partial_sum, probe[63:32]}), 64'd0);
        wait_done("re");
        check("re_sum",    64'(partial_sum), 64'd496);
        start = 1'b0; tick(); tick();

        // Unaligned base rounds down to burst boundary
        prep_run(); ddr_baseaddr = 32'h1000_0014; start = 1'b1;
        wait_done("ua");
        check("ua_ar0", 64'(ar_log[0]), 64'h1000_0000);
        check("ua_sum", 64'(partial_sum), 64'd496);
        start = 1'b0; ddr_baseaddr = MBASE; tick(); tick();

        // Asynchronous reset mid-run, start held high across release
        prep_run(); start = 1'b1;
        repeat (6) tick();
        check("mr_busy", 64'(busy), 64'd1);
        #1 rst = 1'b1;
        #1;
        check("mr_arvalid", 64'(arvalid), 64'd0);
        check("mr_rready",  64'(rready), 64'd0);
        check("mr_probe",   64'(probe == '0), 64'd1);
        check("mr_sum",     64'(partial_sum), 64'd0);
        tick(); tick();
        rst = 1'b0;
        repeat (5) tick();
        check("mr_norun", 64'({busy, arvalid, probe[129:128]}), 64'd0);
        start = 1'b0; tick();
        prep_run(); start = 1'b1;
        wait_done("mr");
        check("mr_rsum", 64'(partial_sum), 64'd496);
        check("mr_rerr", 64'(probe[127:96]), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
